// File: rtl/wb_load_return_queue.sv
// In-order writeback queue between MEM and the register file. Non-load entries
// are complete on entry. Loads wait for their in-order dmem response and are extended on fill.
module wb_load_return_queue #(
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64,
  parameter int BYPASS  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_rd,
  input  logic                       in_we,
  input  logic [2:0]                 in_sel,
  input  logic [1:0]                 in_addr_lo,
  input  logic [31:0]                in_value,
  input  logic [ORDER_W-1:0]         in_order,
  input  logic                       dmem_resp,
  input  logic [31:0]                dmem_rdata,
  output logic                       regf_we,
  output logic [4:0]                 rd_sel,
  output logic [31:0]                rd_v,
  output logic                       retire_valid,
  output logic [ORDER_W-1:0]         retire_order,
  output logic [$clog2(DEPTH):0]     loads_pending,
  output logic                       resp_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  function automatic logic is_load(input logic [2:0] sel);
    return (sel >= 3'd1) && (sel <= 3'd5);
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0]  sel,
                                              input logic [1:0]  a,
                                              input logic [31:0] w);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r;
    b_s = signed'(8'(w >> {a, 3'b000}));
    h_s = signed'(a[1] ? w[31:16] : w[15:0]);
    case (sel)
      3'd1:    r = 32'(b_s);
      3'd2:    r = {24'd0, b_s};
      3'd3:    r = 32'(h_s);
      3'd4:    r = {16'd0, h_s};
      default: r = w;
    endcase
    return r;
  endfunction

  // Entry payload: data only, never reset.
  logic [4:0]         rd_q  [DEPTH];
  logic               we_q  [DEPTH];
  logic [2:0]         sel_q [DEPTH];
  logic [1:0]         alo_q [DEPTH];
  logic [31:0]        val_q [DEPTH];
  logic [ORDER_W-1:0] ord_q [DEPTH];

  // Control state. A set pend bit marks a load still waiting for its data.
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d, lp_q, lp_d;
  logic             err_q, err_d;

  logic             accept, in_is_ld, byp, push, pop, fill, found;
  logic [PTR_W-1:0] fill_idx, slot;

  always_comb begin
    in_ready = (count_q != FULL);
    accept   = in_valid && in_ready;
    in_is_ld = is_load(in_sel);
    byp      = (BYPASS != 0) && accept && !in_is_ld && (count_q == '0);
    push     = accept && !byp;
    pop      = (count_q != '0) && !pend_q[head_q];
    fill     = dmem_resp && (lp_q != '0);

    // Oldest pending load, searched from the head in enqueue order.
    fill_idx = head_q;
    found    = 1'b0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if (!found && ((PTR_W+1)'(i) < count_q) && pend_q[slot]) begin
        found    = 1'b1;
        fill_idx = slot;
      end
    end

    pend_d = pend_q;
    if (fill) pend_d[fill_idx] = 1'b0;
    if (push) pend_d[tail_q] = in_is_ld;

    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    lp_d    = lp_q + (PTR_W+1)'(push && in_is_ld) - (PTR_W+1)'(fill);
    err_d   = err_q || (dmem_resp && (lp_q == '0));
  end

  always_comb begin
    retire_valid = pop || byp;
    regf_we      = 1'b0;
    rd_sel       = '0;
    rd_v         = '0;
    retire_order = '0;
    if (byp) begin
      regf_we      = in_we && (in_rd != 5'd0);
      rd_sel       = in_rd;
      rd_v         = regf_we ? in_value : 32'd0;
      retire_order = in_order;
    end else if (pop) begin
      regf_we      = we_q[head_q] && (rd_q[head_q] != 5'd0);
      rd_sel       = rd_q[head_q];
      rd_v         = regf_we ? val_q[head_q] : 32'd0;
      retire_order = ord_q[head_q];
    end
  end

  assign loads_pending = lp_q;
  assign resp_err      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      lp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      lp_q    <= lp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]  <= in_rd;
      we_q[tail_q]  <= in_we;
      sel_q[tail_q] <= in_sel;
      alo_q[tail_q] <= in_addr_lo;
      val_q[tail_q] <= in_is_ld ? 32'd0 : in_value;
      ord_q[tail_q] <= in_order;
    end
    if (fill) begin
      val_q[fill_idx] <= load_extend(sel_q[fill_idx], alo_q[fill_idx], dmem_rdata);
    end
  end

endmodule
